serial_byte_deser: RTL and testbench
====================================

// Module: serial_byte_deser
// PURPOSE
//  Serial-to-parallel deserializer fed by the dff latch stage. It shifts in the registered serial bit
//  stream one bit per qualified cycle, frames bytes between sof/eof markers and hands each completed
//  byte downstream over a valid/ready handshake through a one-entry holding register.
//  Sits between the bit-capture flop and the ICMP packet parser.
// PARAMETERS
//  DATA_W     8   bits per output word
//  MSB_FIRST  1   1: first received bit lands in byte_out[DATA_W-1]; 0: in byte_out[0]
//  CNT_W      16  width of per-frame word counter
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous, active-high reset
//  d           in   1       serial data bit (q of upstream dff)
//  d_valid     in   1       d is meaningful this cycle
//  sof         in   1       qualified by d_valid: this bit is the first bit of a frame
//  eof         in   1       qualified by d_valid: this bit is the last bit of a frame
//  byte_out    out  DATA_W  completed word
//  byte_valid  out  1       byte_out holds an undelivered word
//  byte_ready  in   1       downstream accepts when byte_valid & byte_ready
//  byte_last   out  1       byte_out is the final word of its frame
//  word_count  out  CNT_W   words completed in current/last frame
//  overflow    out  1       sticky: a word was dropped because holding reg was full
//  frame_err   out  1       sticky: eof arrived with a partial word (bit count % DATA_W != 0)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, shift reg/bit counter=0, byte_out=0, byte_valid=0,
//    byte_last=0, word_count=0, overflow=0, frame_err=0. Reset mid-frame discards all partial data.
//  - States: IDLE -> RECV on d_valid&sof; RECV -> IDLE on d_valid&eof; d_valid without sof in IDLE ignored.
//  - sof in RECV: partial word discarded (no error), bit counter and word_count restart; bit is bit 0.
//  - sof&eof same cycle: single-bit frame; DATA_W>1 so frame_err sets, state stays IDLE.
//  - Each d_valid bit in RECV (or the sof bit) shifts in per MSB_FIRST; bit counter increments mod DATA_W.
//  - Word completes on the cycle the DATA_W-th bit is shifted in; it loads the holding reg at that
//    clk edge if byte_valid=0 or byte_ready=1 that cycle (simultaneous drain+load allowed, no bubble).
//    byte_valid rises the following cycle: latency = 1 clk from last bit to byte_valid.
//  - Holding reg full and not draining at completion: word dropped, overflow<=1, word_count unchanged.
//  - byte_last = 1 when the loaded word completed on an eof bit.
//  - eof with partial word: partial discarded, frame_err<=1, byte_last not asserted for any word.
//  - byte_valid stays high and byte_out stable until handshake; deassert only after byte_ready.
//  - word_count saturates at 2^CNT_W-1; cleared on sof.
//  - overflow/frame_err clear only on rst.
// CONFIGURATION
//  ICMP_CSUM_EN defined: adds outputs csum[15:0] and csum_ok. Words are paired big-endian into 16-bit
//    halves (odd trailing byte padded with 0x00), summed ones-complement with end-around carry;
//    accumulator cleared on sof. On the cycle after a byte_last word loads, csum=~sum and
//    csum_ok=(sum==16'hFFFF) for one frame, held until next sof. Requires DATA_W=8.
//  Not defined: ports absent, no accumulator logic; all other behaviour identical.
// STRUCTURE
//  Package deser_pkg: state enum {IDLE,RECV}, CSUM_W=16, CSUM_GOOD=16'hFFFF.
//  Sub-module ones_comp_add16 (16-bit add with end-around carry), instantiated only under ICMP_CSUM_EN.
//  Shift register, bit counter, FSM and holding register live in the top module.
// TESTING
//  1 rst high 2 clk mid-frame -> all outputs 0, next sof starts clean frame.
//  2 sof + bits 1,0,1,0,0,1,0,1 then eof, byte_ready=1 -> byte_out=8'hA5, byte_valid 1 clk after last bit, byte_last=1, word_count=1.
//  3 two frames' bytes 8'h12,8'h34 with byte_ready=0 -> first held, second dropped, overflow=1, byte_out stays 8'h12.
//  4 eof after 12 bits -> one word delivered, frame_err=1, byte_last=0.
//  5 sof in RECV after 5 bits -> partial discarded, next 8 bits produce correct byte, frame_err=0.
//  6 (ICMP_CSUM_EN) frame 08 00 F7 FF -> csum=16'h0000, csum_ok=1; corrupt one byte -> csum_ok=0.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and constants for the serial byte deserializer.
// ICMP_CSUM_EN enables the ICMP checksum outputs.
package deser_pkg;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  localparam int CSUM_W = 16;
  localparam logic [CSUM_W-1:0] CSUM_GOOD = 16'hFFFF;

endpackage

// File: rtl/ones_comp_add16.sv
// 16-bit ones-complement adder: the carry out of bit 15
// wraps back into bit 0 (end-around carry).
module ones_comp_add16
  import deser_pkg::*;
(
  input  logic [CSUM_W-1:0] a,
  input  logic [CSUM_W-1:0] b,
  output logic [CSUM_W-1:0] sum
);

  logic [CSUM_W:0] raw;

  // Plain add, then fold the carry back in.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    sum = raw[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, raw[CSUM_W]};
  end

endmodule

// File: rtl/serial_byte_deser.sv
// Serial-to-parallel deserializer with sof/eof framing and a one-entry output hold register.
// ICMP_CSUM_EN adds csum/csum_ok (ones-complement frame checksum, DATA_W must be 8).
module serial_byte_deser
  import deser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  input  logic              d_valid,
  input  logic              sof,
  input  logic              eof,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last,
  output logic [CNT_W-1:0]  word_count,
  output logic              overflow,
  output logic              frame_err
`ifdef ICMP_CSUM_EN
  ,
  output logic [CSUM_W-1:0] csum,
  output logic              csum_ok
`endif
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [BCW-1:0]     bitcnt;

  logic               take;
  logic               done;
  logic               can_load;
  logic               load;
  logic [BCW-1:0]     cnt_cur;
  logic [DATA_W-1:0]  sh_cur;
  logic [DATA_W-1:0]  sh_nxt;
  logic [CNT_W-1:0]   wc_cur;

  // A sof bit restarts the word: it is shifted in on top of an empty register.
  always_comb begin
    take     = d_valid & (sof | (state == RECV));
    cnt_cur  = sof ? '0 : bitcnt;
    sh_cur   = sof ? '0 : shreg;
    wc_cur   = sof ? '0 : word_count;
    if (MSB_FIRST) sh_nxt = {sh_cur[DATA_W-2:0], d};
    else           sh_nxt = {d, sh_cur[DATA_W-1:1]};
    done     = take & (cnt_cur == LAST_BIT);
    can_load = ~byte_valid | byte_ready;
    load     = done & can_load;
  end

  // Framing FSM, shifter, hold register and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (byte_valid & byte_ready) byte_valid <= 1'b0;
      if (take) begin
        state      <= eof ? IDLE : RECV;
        shreg      <= (done | eof) ? '0 : sh_nxt;
        bitcnt     <= (done | eof) ? '0 : cnt_cur + BCW'(1);
        word_count <= wc_cur;
        if (eof & ~done) frame_err <= 1'b1;
      end
      if (load) begin
        byte_out   <= sh_nxt;
        byte_valid <= 1'b1;
        byte_last  <= eof;
        if (~&wc_cur) word_count <= wc_cur + CNT_W'(1);
      end
      if (done & ~can_load) overflow <= 1'b1;
    end
  end

`ifdef ICMP_CSUM_EN
  logic [7:0]        hi_byte;
  logic              odd;
  logic [CSUM_W-1:0] acc;
  logic [CSUM_W-1:0] operand;
  logic [CSUM_W-1:0] acc_nxt;

  // Even words are the high half of a pair; a lone last word is padded.
  always_comb begin
    operand = odd ? {hi_byte, sh_nxt[7:0]} : {sh_nxt[7:0], 8'h00};
  end

  ones_comp_add16 u_add (
    .a   (acc),
    .b   (operand),
    .sum (acc_nxt)
  );

  // Accumulate loaded words; publish the result when the last word loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_byte <= '0;
      odd     <= 1'b0;
      acc     <= '0;
      csum    <= '0;
      csum_ok <= 1'b0;
    end else if (take & sof) begin
      odd     <= 1'b0;
      acc     <= '0;
      csum    <= '0;
      csum_ok <= 1'b0;
    end else if (load) begin
      odd     <= ~odd;
      hi_byte <= sh_nxt[7:0];
      if (odd | eof) acc <= acc_nxt;
      if (eof) begin
        csum    <= ~acc_nxt;
        csum_ok <= (acc_nxt == CSUM_GOOD);
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_byte_deser.sv
// Directed bench for serial_byte_deser with a scoreboard of delivered words.
// Define ICMP_CSUM_EN to also exercise the checksum outputs.
module tb_serial_byte_deser;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d = 1'b0;
  logic        d_valid = 1'b0;
  logic        sof = 1'b0;
  logic        eof = 1'b0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_last;
  logic [15:0] word_count;
  logic        overflow;
  logic        frame_err;
`ifdef ICMP_CSUM_EN
  logic [15:0] csum;
  logic        csum_ok;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_byte_deser dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .d_valid    (d_valid),
    .sof        (sof),
    .eof        (eof),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .word_count (word_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
`ifdef ICMP_CSUM_EN
    ,
    .csum       (csum),
    .csum_ok    (csum_ok)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic s, input logic e);
    @(posedge clk);
    #1;
    d = b;
    d_valid = 1'b1;
    sof = s;
    eof = e;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n,
                           input logic s, input logic e);
    for (int i = n - 1; i >= 0; i--)
      send_bit(v[i], s && (i == n - 1), e && (i == 0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      d_valid = 1'b0;
      sof = 1'b0;
      eof = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] v, input logic l);
    exp_t e;
    e.data = v;
    e.last = l;
    sb.push_back(e);
  endtask

  // Scoreboard: every handshake pops one expected word.
  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {24'h0, byte_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", {24'h0, byte_out}, {24'h0, e.data});
        chk("sb_last", {31'h0, byte_last}, {31'h0, e.last});
      end
    end
  end

  initial begin
    // Test 1: reset state, then reset in the middle of a frame.
    idle(2);
    @(negedge clk);
    chk("rst_valid", {31'h0, byte_valid}, 32'h0);
    chk("rst_wc", {16'h0, word_count}, 32'h0);
    rst = 1'b0;
    byte_ready = 1'b0;
    send_bits(16'h00FF, 8, 1'b1, 1'b0);
    send_bits(16'h0005, 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", {31'h0, byte_valid}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    d_valid = 1'b0;
    idle(2);
    @(negedge clk);
    chk("midrst_out", {24'h0, byte_out}, 32'h0);
    chk("midrst_valid", {31'h0, byte_valid}, 32'h0);
    chk("midrst_last", {31'h0, byte_last}, 32'h0);
    chk("midrst_wc", {16'h0, word_count}, 32'h0);
    chk("midrst_flags", {30'h0, overflow, frame_err}, 32'h0);
    rst = 1'b0;
    byte_ready = 1'b1;

    // Test 2: A5 with eof on the last bit, one-cycle latency.
    push(8'hA5, 1'b1);
    send_bits(16'h00A5, 8, 1'b1, 1'b1);
    @(negedge clk);
    chk("a5_lat0", {31'h0, byte_valid}, 32'h0);
    idle(1);
    @(negedge clk);
    chk("a5_valid", {31'h0, byte_valid}, 32'h1);
    chk("a5_last", {31'h0, byte_last}, 32'h1);
    chk("a5_wc", {16'h0, word_count}, 32'h1);
    idle(2);

    // Test 5: sof while receiving discards the partial word.
    send_bits(16'h0015, 5, 1'b1, 1'b0);
    push(8'h5A, 1'b1);
    send_bits(16'h005A, 8, 1'b1, 1'b1);
    idle(3);
    @(negedge clk);
    chk("resof_ferr", {31'h0, frame_err}, 32'h0);
    chk("resof_wc", {16'h0, word_count}, 32'h1);

    // Test 4: eof after 12 bits.
    push(8'h3C, 1'b0);
    send_bits(16'h03C5, 12, 1'b1, 1'b1);
    idle(3);
    @(negedge clk);
    chk("eof12_ferr", {31'h0, frame_err}, 32'h1);
    chk("eof12_last", {31'h0, byte_last}, 32'h0);
    chk("eof12_wc", {16'h0, word_count}, 32'h1);

    // Test 3: stalled output, second frame's word dropped.
    byte_ready = 1'b0;
    push(8'h12, 1'b1);
    send_bits(16'h0012, 8, 1'b1, 1'b1);
    send_bits(16'h0034, 8, 1'b1, 1'b1);
    idle(3);
    @(negedge clk);
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
    chk("ovf_hold", {24'h0, byte_out}, 32'h12);
    chk("ovf_valid", {31'h0, byte_valid}, 32'h1);
    chk("ovf_wc", {16'h0, word_count}, 32'h0);
    byte_ready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("ovf_drained", {31'h0, byte_valid}, 32'h0);

`ifdef ICMP_CSUM_EN
    // Test 6: checksum over a good and a corrupted ICMP header.
    push(8'h08, 1'b0);
    push(8'h00, 1'b0);
    push(8'hF7, 1'b0);
    push(8'hFF, 1'b1);
    send_bits(16'h0008, 8, 1'b1, 1'b0);
    send_bits(16'h0000, 8, 1'b0, 1'b0);
    send_bits(16'h00F7, 8, 1'b0, 1'b0);
    send_bits(16'h00FF, 8, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    chk("csum_good", {16'h0, csum}, 32'h0);
    chk("csum_ok_good", {31'h0, csum_ok}, 32'h1);
    push(8'h08, 1'b0);
    push(8'h00, 1'b0);
    push(8'hF7, 1'b0);
    push(8'hFE, 1'b1);
    send_bits(16'h0008, 8, 1'b1, 1'b0);
    send_bits(16'h0000, 8, 1'b0, 1'b0);
    send_bits(16'h00F7, 8, 1'b0, 1'b0);
    send_bits(16'h00FE, 8, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    chk("csum_bad", {16'h0, csum}, 32'h1);
    chk("csum_ok_bad", {31'h0, csum_ok}, 32'h0);
    idle(2);
`endif

    // Sticky flags clear only on reset.
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    @(negedge clk);
    chk("final_flags", {30'h0, overflow, frame_err}, 32'h0);
    chk("sb_empty", sb.size(), 32'h0);
    rst = 1'b0;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
